// File: rtl/ad7928_pkg.sv
// Shared constants for the AD7928 SPI responder: control-word field
// positions, frame length, FSM encoding and a channel-select helper.
package ad7928_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CH_W       = 12;
    localparam int NUM_CH     = 8;

    // Control-word bit positions (MSB first on the wire)
    localparam int CW_WRITE   = 15;
    localparam int CW_SEQ     = 14;
    localparam int CW_ADD_HI  = 12;
    localparam int CW_ADD_LO  = 10;
    localparam int CW_PM_HI   = 9;
    localparam int CW_PM_LO   = 8;
    localparam int CW_SHADOW  = 7;
    localparam int CW_RANGE   = 5;
    localparam int CW_CODING  = 4;

    // Responder FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_TAIL   = 2'd2;

    // Pick one 12-bit channel value out of the packed 8-channel bus
    function automatic logic [CH_W-1:0] ch_sel(input logic [NUM_CH*CH_W-1:0] vals,
                                               input logic [2:0] ch);
        logic [CH_W-1:0] r;
        r = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (ch == 3'(n)) r = vals[CH_W*n +: CH_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/ad7928_spi_responder_spi_pin_sync.sv
// N-stage pin synchronizer with registered rise/fall strobes.
// Level and strobes come out of the same register stage so they stay aligned;
// pin-to-strobe latency is STAGES+1 clocks.
module spi_pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic I_clk,
    input  logic I_rst,
    input  logic I_pin,
    output logic O_level,
    output logic O_rise,
    output logic O_fall
);

    logic [STAGES-1:0] sync_q;

    // Synchronizer chain, then one more stage for edge detection
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            sync_q  <= {STAGES{RST_VAL}};
            O_level <= RST_VAL;
            O_rise  <= 1'b0;
            O_fall  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], I_pin};
            O_level <= sync_q[STAGES-1];
            O_rise  <= sync_q[STAGES-1] & ~O_level;
            O_fall  <= ~sync_q[STAGES-1] & O_level;
        end
    end

endmodule

// File: rtl/ad7928_spi_responder.sv
// AD7928 ADC emulator: SPI slave that answers {0, ADD, DATA} frames from a
// parallel channel bus and tracks the channel address written by the master.
module ad7928_spi_responder
    import ad7928_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                   I_clk,
    input  logic                   I_rst,
    input  logic                   I_spi_ss,
    input  logic                   I_spi_sck,
    input  logic                   I_spi_mosi,
    output logic                   O_spi_miso,
    output logic                   O_spi_miso_oe,
    input  logic [NUM_CH*CH_W-1:0] I_ch_values,
    output logic                   O_frame_done,
    output logic [FRAME_BITS-1:0]  O_ctrl_word,
    output logic [2:0]             O_cur_channel
);

    logic ss_fall, ss_rise, sck_fall, mosi_level;
    logic ss_level_unused, sck_level_unused, sck_rise_unused;
    logic mosi_rise_unused, mosi_fall_unused;

    logic [1:0]            state;
    logic [4:0]            bit_cnt;
    logic [FRAME_BITS-1:0] tx_sr;
    logic [FRAME_BITS-1:0] rx_sr;
    logic [FRAME_BITS-1:0] rx_next;

    // SS and SCK idle high, so their chains reset high to avoid false edges
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .I_clk(I_clk), .I_rst(I_rst), .I_pin(I_spi_ss),
        .O_level(ss_level_unused), .O_rise(ss_rise), .O_fall(ss_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
        .I_clk(I_clk), .I_rst(I_rst), .I_pin(I_spi_sck),
        .O_level(sck_level_unused), .O_rise(sck_rise_unused), .O_fall(sck_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .I_clk(I_clk), .I_rst(I_rst), .I_pin(I_spi_mosi),
        .O_level(mosi_level), .O_rise(mosi_rise_unused), .O_fall(mosi_fall_unused)
    );

    assign rx_next       = {rx_sr[FRAME_BITS-2:0], mosi_level};
    assign O_spi_miso_oe = (state != ST_IDLE);

    // Frame FSM: load TX on select, shift both registers on SCK falls,
    // commit the control word only when a full frame completes
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            tx_sr         <= '0;
            rx_sr         <= '0;
            O_spi_miso    <= 1'b0;
            O_frame_done  <= 1'b0;
            O_ctrl_word   <= '0;
            O_cur_channel <= '0;
        end else begin
            O_frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    O_spi_miso <= 1'b0;
                    if (ss_fall) begin
                        tx_sr      <= {1'b0, O_cur_channel, ch_sel(I_ch_values, O_cur_channel)};
                        rx_sr      <= '0;
                        bit_cnt    <= '0;
                        O_spi_miso <= 1'b0;
                        state      <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (ss_rise) begin
                        O_spi_miso <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (sck_fall) begin
                        rx_sr      <= rx_next;
                        tx_sr      <= {tx_sr[FRAME_BITS-2:0], 1'b0};
                        O_spi_miso <= tx_sr[FRAME_BITS-2];
                        bit_cnt    <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'(FRAME_BITS - 1)) begin
                            O_spi_miso   <= 1'b0;
                            O_ctrl_word  <= rx_next;
                            O_frame_done <= 1'b1;
                            if (rx_next[CW_WRITE])
                                O_cur_channel <= rx_next[CW_ADD_HI:CW_ADD_LO];
                            state <= ST_TAIL;
                        end
                    end
                end
                ST_TAIL: begin
                    O_spi_miso <= 1'b0;
                    if (ss_rise) state <= ST_IDLE;
                end
                default: begin
                    O_spi_miso <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
